// File: rtl/disp7_pkg.sv
// Shared types, seven-segment patterns and the BCD decode function
// used by the digit scanner.
package disp7_pkg;

    typedef logic [3:0] bcd_t;

    // Segment order is {g,f,e,d,c,b,a}, active-high.
    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_DASH  = 7'h40;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    // Codes 10..15 are not BCD and show a dash so a bad counter is visible.
    function automatic logic [6:0] bcd_decode(input bcd_t i_bcd);
        case (i_bcd)
            4'd0:    return SEG_0;
            4'd1:    return SEG_1;
            4'd2:    return SEG_2;
            4'd3:    return SEG_3;
            4'd4:    return SEG_4;
            4'd5:    return SEG_5;
            4'd6:    return SEG_6;
            4'd7:    return SEG_7;
            4'd8:    return SEG_8;
            4'd9:    return SEG_9;
            default: return SEG_DASH;
        endcase
    endfunction

endpackage

// File: rtl/disp7_scan_if.sv
// Digit-load and display bus between the counter chain (master) and the
// seven-segment scanner (slave).
interface disp7_scan_if #(parameter int N_DIG = 4);
    import disp7_pkg::*;

    logic                   load;
    bcd_t [N_DIG-1:0]       digits;   // digit i occupies bits [4i+3:4i]
    logic [6:0]             seg;
    logic [N_DIG-1:0]       an;

    modport master (output load, digits, input  seg, an);
    modport slave  (input  load, digits, output seg, an);

endinterface

// File: rtl/bcd_to_seg7.sv
// Combinational BCD to seven-segment decoder; one instance sits on the
// currently selected digit.
module bcd_to_seg7
    import disp7_pkg::*;
(
    input  bcd_t       i_bcd,
    output logic [6:0] o_seg
);

    assign o_seg = bcd_decode(i_bcd);

endmodule

// File: rtl/disp7_scan.sv
// Multiplexed seven-segment scanner: shadow register, prescaler, scan index
// and registered outputs. Define DISP_LZB_EN to enable leading-zero blanking.
module disp7_scan
    import disp7_pkg::*;
#(
    parameter int N_DIG    = 4,
    parameter int SCAN_DIV = 4
) (
    input  logic         clk,
    input  logic         rst,
    disp7_scan_if.slave  bus
);

    localparam int PC_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W = (N_DIG > 1) ? $clog2(N_DIG) : 1;

    localparam logic [PC_W-1:0]  PC_LAST  = PC_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIG - 1);
    localparam logic [N_DIG-1:0] AN_ONE   = N_DIG'(1);

    bcd_t [N_DIG-1:0] r_sh;
    logic [PC_W-1:0]  r_pc;
    logic [IDX_W-1:0] r_idx;
    logic [N_DIG-1:0] r_an;
    logic [6:0]       r_seg;

    logic             w_tick;
    bcd_t             w_digit;
    logic [6:0]       w_dec;
    logic             w_blank;
    logic [6:0]       w_seg_next;

    assign w_tick  = (r_pc == PC_LAST);
    assign w_digit = r_sh[r_idx];

    bcd_to_seg7 u_dec (
        .i_bcd (w_digit),
        .o_seg (w_dec)
    );

`ifdef DISP_LZB_EN
    // w_lz[i] is set when digit i and every more significant digit are zero.
    logic [N_DIG-1:0] w_lz;

    // NOTE: every variable written here gets a value before any condition,
    // so no path leaves it unassigned and no latch is inferred.
    always_comb begin : lz_scan
        logic v_run;
        v_run = 1'b1;
        w_lz  = '0;
        for (int i = N_DIG - 1; i >= 0; i--) begin
            v_run   = v_run && (r_sh[i] == 4'd0);
            w_lz[i] = v_run;
        end
    end

    assign w_blank = (r_idx != '0) && w_lz[r_idx];
`else
    assign w_blank = 1'b0;
`endif

    assign w_seg_next = w_blank ? SEG_BLANK : w_dec;

    // Outputs are taken from the pre-edge idx and sh, so a load or an index
    // step becomes visible one edge later and never mixes within a slot.
    // NOTE: all state uses non-blocking assignments so every register samples
    // the pre-edge values; the shadow register is reset because zero is shown.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sh  <= '0;
            r_pc  <= '0;
            r_idx <= '0;
            r_an  <= '0;
            r_seg <= '0;
        end else begin
            if (bus.load) begin
                r_sh <= bus.digits;
            end
            r_pc <= w_tick ? '0 : r_pc + 1'b1;
            if (w_tick) begin
                r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
            end
            r_an  <= AN_ONE << r_idx;
            r_seg <= w_seg_next;
        end
    end

    assign bus.an  = r_an;
    assign bus.seg = r_seg;

endmodule

// File: tb/tb_disp7_scan.sv
// Directed, table-driven bench for disp7_scan with N_DIG=4, SCAN_DIV=4;
// expectations follow DISP_LZB_EN when it is defined.
module tb_disp7_scan;
    import disp7_pkg::*;

    localparam int N_DIG    = 4;
    localparam int SCAN_DIV = 4;
    localparam int FRAME    = N_DIG * SCAN_DIV;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    disp7_scan_if #(.N_DIG(N_DIG)) bus ();

    disp7_scan #(.N_DIG(N_DIG), .SCAN_DIV(SCAN_DIV)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        string           name;
        logic [15:0]     digits;
        logic [3:0][6:0] exp_seg;   // {digit3, digit2, digit1, digit0}
    } vec_t;

    vec_t vecs [7];

    int checks   = 0;
    int failures = 0;
    int n_edge   = 0;   // rising edges since reset was released

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        n_edge++;
    endtask

    // After edge n the displayed digit is the one selected before that edge.
    function automatic int exp_digit(input int n);
        return ((n - 1) / SCAN_DIV) % N_DIG;
    endfunction

    function automatic logic [3:0] exp_an(input int n);
        return 4'(1 << exp_digit(n));
    endfunction

    task automatic check_frame(input string name, input logic [3:0][6:0] exp_seg);
        int d;
        for (int c = 0; c < FRAME; c++) begin
            step();
            d = exp_digit(n_edge);
            check($sformatf("%s an e%0d", name, n_edge), 32'(bus.an), 32'(exp_an(n_edge)));
            check($sformatf("%s seg d%0d", name, d), 32'(bus.seg), 32'(exp_seg[d]));
        end
    endtask

    task automatic load_word(input logic [15:0] w);
        bus.digits = w;
        bus.load   = 1'b1;
        step();
        bus.load   = 1'b0;
    endtask

    initial begin
        vecs[0] = '{"v0000", 16'h0000, {7'h3F, 7'h3F, 7'h3F, 7'h3F}};
        vecs[1] = '{"v1234", 16'h1234, {7'h06, 7'h5B, 7'h4F, 7'h66}};
        vecs[2] = '{"v00A9", 16'h00A9, {7'h3F, 7'h3F, 7'h40, 7'h6F}};
        vecs[3] = '{"v0050", 16'h0050, {7'h3F, 7'h3F, 7'h6D, 7'h3F}};
        vecs[4] = '{"v9876", 16'h9876, {7'h6F, 7'h7F, 7'h07, 7'h7D}};
        vecs[5] = '{"vF0B0", 16'hF0B0, {7'h40, 7'h3F, 7'h40, 7'h3F}};
        vecs[6] = '{"v0300", 16'h0300, {7'h3F, 7'h4F, 7'h3F, 7'h3F}};
`ifdef DISP_LZB_EN
        vecs[0].exp_seg = {7'h00, 7'h00, 7'h00, 7'h3F};
        vecs[2].exp_seg = {7'h00, 7'h00, 7'h40, 7'h6F};
        vecs[3].exp_seg = {7'h00, 7'h00, 7'h6D, 7'h3F};
        vecs[6].exp_seg = {7'h00, 7'h4F, 7'h3F, 7'h3F};
`endif

        rst        = 1'b0;
        bus.load   = 1'b0;
        bus.digits = '0;

        // Reset held for three cycles, then the power-on frame of zeros.
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            check("rst an", 32'(bus.an), 32'h0);
            check("rst seg", 32'(bus.seg), 32'h0);
        end
        rst    = 1'b1;
        n_edge = 0;
        check_frame("reset_frame", vecs[0].exp_seg);

        for (int v = 0; v < 7; v++) begin
            load_word(vecs[v].digits);
            check_frame(vecs[v].name, vecs[v].exp_seg);
        end

        // Two loads inside one digit-0 slot.
        while ((n_edge % FRAME) != 0) step();
        load_word(16'h0007);
        check("mid an0", 32'(bus.an), 32'h1);
        step();
        check("mid seg7", 32'(bus.seg), 32'h07);
        check("mid an1", 32'(bus.an), 32'h1);
        bus.digits = 16'h0008;
        bus.load   = 1'b1;
        step();
        bus.load   = 1'b0;
        check("mid seg7 hold", 32'(bus.seg), 32'h07);
        check("mid an2", 32'(bus.an), 32'h1);
        step();
        check("mid seg8", 32'(bus.seg), 32'h7F);
        check("mid an3", 32'(bus.an), 32'h1);

        // Asynchronous reset while digit 2 is displayed.
        while (exp_an(n_edge) != 4'b0100) step();
        check("pre_rst an", 32'(bus.an), 32'h4);
        #2;
        rst = 1'b0;
        #1;
        check("async an", 32'(bus.an), 32'h0);
        check("async seg", 32'(bus.seg), 32'h0);
        @(posedge clk);
        #1;
        check("async hold an", 32'(bus.an), 32'h0);
        check("async hold seg", 32'(bus.seg), 32'h0);
        rst    = 1'b1;
        n_edge = 0;
        check_frame("post_rst", vecs[0].exp_seg);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
